// File: rtl/mic1_pkg.sv
// Shared definitions for the MIC-1 memory-interface controller.
package mic1_pkg;

    // Per-channel request state.
    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_BUSY = 1'b1
    } chan_state_t;

    // Default widths and timeout.
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_BYTE_W  = 8;
    localparam int DEF_TIMEOUT = 15;
    localparam int DEF_TO_W    = 4;

    // Memory-control bit positions inside the 36-bit MIR (B field is [3:0]).
    localparam int MIR_FETCH_BIT = 4;
    localparam int MIR_RD_BIT    = 5;
    localparam int MIR_WR_BIT    = 6;

endpackage

// File: rtl/mic1_mem_chan.sv
// One memory channel: IDLE/BUSY FSM, registered request, timeout counter
// and a registered load pulse carrying the returned data.
module mic1_mem_chan
    import mic1_pkg::*;
#(
    parameter int ADDR_W   = 30,
    parameter int RDATA_W  = 32,
    parameter int WRITE_EN = 1,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int TO_W     = DEF_TO_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               issue,
    input  logic               issue_we,
    input  logic [ADDR_W-1:0]  issue_addr,
    input  logic               ack,
    input  logic [RDATA_W-1:0] rdata,
    output logic               req,
    output logic               we,
    output logic [ADDR_W-1:0]  addr,
    output logic               load,
    output logic [RDATA_W-1:0] load_data,
    output logic               busy,
    output logic               timeout
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    chan_state_t        state_reg, state_next;
    logic               req_reg, we_reg, load_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [RDATA_W-1:0] load_data_reg;
    logic [TO_W-1:0]    cnt_reg;
    logic               ack_seen, expire;

    // Ack only counts while the request is actually on the port.
    assign ack_seen = (state_reg == CH_BUSY) & req_reg & ack;
    assign expire   = (state_reg == CH_BUSY) & req_reg & ~ack & (cnt_reg == TO_LAST);

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) state_reg <= CH_IDLE;
        else        state_reg <= state_next;
    end

    // Next state: leave BUSY on ack or on timeout abort.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CH_IDLE: if (issue) state_next = CH_BUSY;
            CH_BUSY: if (ack_seen || expire) state_next = CH_IDLE;
            default: state_next = CH_IDLE;
        endcase
    end

    // Request registers, timeout counter and load pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            req_reg       <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            cnt_reg       <= '0;
            load_reg      <= 1'b0;
            load_data_reg <= '0;
        end else begin
            load_reg <= 1'b0;
            if (state_reg == CH_IDLE && issue) begin
                req_reg  <= 1'b1;
                we_reg   <= issue_we & (WRITE_EN != 0);
                addr_reg <= issue_addr;
                cnt_reg  <= '0;
            end else if (ack_seen) begin
                req_reg  <= 1'b0;
                load_reg <= ~we_reg;
                if (!we_reg) load_data_reg <= rdata;
            end else if (expire) begin
                // Aborted reads still pulse (with zero) so dependent stalls release.
                req_reg  <= 1'b0;
                load_reg <= ~we_reg;
                if (!we_reg) load_data_reg <= '0;
            end else if (state_reg == CH_BUSY) begin
                cnt_reg <= cnt_reg + TO_W'(1);
            end
        end
    end

    assign req       = req_reg;
    assign we        = we_reg;
    assign addr      = addr_reg;
    assign load      = load_reg;
    assign load_data = load_data_reg;
    assign busy      = (state_reg == CH_BUSY);
    assign timeout   = expire;

endmodule

// File: rtl/mic1_mem_ctrl.sv
// MIC-1 memory controller: data and fetch channels, microsequencer stall,
// write-data snapshot and sticky error flags.
module mic1_mem_ctrl
    import mic1_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int BYTE_W  = DEF_BYTE_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TO_W    = DEF_TO_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mir_rd,
    input  logic              mir_wr,
    input  logic              mir_fetch,
    input  logic              use_mdr,
    input  logic              use_mbr,
    input  logic [DATA_W-1:0] mar,
    input  logic [DATA_W-1:0] mdr,
    input  logic [DATA_W-1:0] pc,
    output logic              stall,
    output logic              mdr_load,
    output logic [DATA_W-1:0] mdr_data,
    output logic              mbr_load,
    output logic [BYTE_W-1:0] mbr_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-3:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [BYTE_W-1:0] imem_rdata,
    output logic              err_timeout,
    output logic              err_rdwr
);

    logic              d_busy, d_we, d_to, d_issue;
    logic              f_busy, f_we, f_to, f_issue;
    logic              stall_c;
    logic [DATA_W-1:0] wdata_reg;
    logic              err_timeout_reg, err_rdwr_reg;

    // A pending read blocks its consumer until the load pulse; a new request
    // on a busy channel waits for it to go idle.
    assign stall_c = (use_mdr & d_busy & ~d_we)
                   | (use_mbr & f_busy & ~f_we)
                   | ((mir_rd | mir_wr) & d_busy)
                   | (mir_fetch & f_busy);

    assign d_issue = (mir_rd | mir_wr) & ~stall_c & ~d_busy;
    assign f_issue = mir_fetch & ~stall_c & ~f_busy;

    mic1_mem_chan #(
        .ADDR_W(DATA_W - 2), .RDATA_W(DATA_W), .WRITE_EN(1),
        .TIMEOUT(TIMEOUT), .TO_W(TO_W)
    ) u_dchan (
        .clock(clock), .reset(reset),
        .issue(d_issue), .issue_we(mir_wr), .issue_addr(mar[DATA_W-1:2]),
        .ack(dmem_ack), .rdata(dmem_rdata),
        .req(dmem_req), .we(d_we), .addr(dmem_addr),
        .load(mdr_load), .load_data(mdr_data),
        .busy(d_busy), .timeout(d_to)
    );

    mic1_mem_chan #(
        .ADDR_W(DATA_W), .RDATA_W(BYTE_W), .WRITE_EN(0),
        .TIMEOUT(TIMEOUT), .TO_W(TO_W)
    ) u_fchan (
        .clock(clock), .reset(reset),
        .issue(f_issue), .issue_we(1'b0), .issue_addr(pc),
        .ack(imem_ack), .rdata(imem_rdata),
        .req(imem_req), .we(f_we), .addr(imem_addr),
        .load(mbr_load), .load_data(mbr_data),
        .busy(f_busy), .timeout(f_to)
    );

    // Snapshot MDR at issue so later MDR writes cannot disturb the transfer.
    always_ff @(posedge clock) begin
        if (!reset)       wdata_reg <= '0;
        else if (d_issue) wdata_reg <= mdr;
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            err_timeout_reg <= 1'b0;
            err_rdwr_reg    <= 1'b0;
        end else begin
            err_timeout_reg <= err_timeout_reg | d_to | f_to;
            err_rdwr_reg    <= err_rdwr_reg | (mir_rd & mir_wr);
        end
    end

    assign stall       = stall_c;
    assign dmem_we     = d_we;
    assign dmem_wdata  = wdata_reg;
    assign err_timeout = err_timeout_reg;
    assign err_rdwr    = err_rdwr_reg;

endmodule

// File: tb/tb_mic1_mem_ctrl.sv
// Self-checking bench for mic1_mem_ctrl: directed scenarios plus randomized
// transactions against a transaction-level memory model.
module tb_mic1_mem_ctrl;

    localparam int DATA_W  = 32;
    localparam int BYTE_W  = 8;
    localparam int TIMEOUT = 15;
    localparam int TO_W    = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              mir_rd, mir_wr, mir_fetch, use_mdr, use_mbr;
    logic [DATA_W-1:0] mar, mdr, pc;
    logic              stall, mdr_load, mbr_load;
    logic [DATA_W-1:0] mdr_data;
    logic [BYTE_W-1:0] mbr_data;
    logic              dmem_req, dmem_we, dmem_ack;
    logic [DATA_W-3:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata, dmem_rdata;
    logic              imem_req, imem_ack;
    logic [DATA_W-1:0] imem_addr;
    logic [BYTE_W-1:0] imem_rdata;
    logic              err_timeout, err_rdwr;

    int checks = 0;
    int errors = 0;

    mic1_mem_ctrl #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clock(clock), .reset(reset),
        .mir_rd(mir_rd), .mir_wr(mir_wr), .mir_fetch(mir_fetch),
        .use_mdr(use_mdr), .use_mbr(use_mbr),
        .mar(mar), .mdr(mdr), .pc(pc),
        .stall(stall), .mdr_load(mdr_load), .mdr_data(mdr_data),
        .mbr_load(mbr_load), .mbr_data(mbr_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .err_timeout(err_timeout), .err_rdwr(err_rdwr)
    );

    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        mir_rd = 0; mir_wr = 0; mir_fetch = 0; use_mdr = 0; use_mbr = 0;
        dmem_ack = 0; imem_ack = 0; dmem_rdata = '0; imem_rdata = '0;
    endtask

    task automatic test_reset();
        reset = 0; idle_inputs();
        mir_rd = 1; mir_fetch = 1; use_mdr = 1; use_mbr = 1; dmem_ack = 1; imem_ack = 1;
        mar = 32'h1234; mdr = 32'h5678; pc = 32'h9ABC;
        cyc(); cyc(); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0b want 0", stall); end
        checks++; if (dmem_req !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got d=%0b f=%0b want 0", dmem_req, imem_req); end
        checks++; if (mdr_load !== 1'b0 || mbr_load !== 1'b0) begin errors++; $display("FAIL rst_load: got %0b %0b want 0", mdr_load, mbr_load); end
        checks++; if (dmem_we !== 1'b0 || dmem_addr !== '0 || dmem_wdata !== '0 || imem_addr !== '0) begin errors++; $display("FAIL rst_regs: got we=%0b a=%h w=%h ia=%h want 0", dmem_we, dmem_addr, dmem_wdata, imem_addr); end
        checks++; if (mdr_data !== '0 || mbr_data !== '0) begin errors++; $display("FAIL rst_data: got %h %h want 0", mdr_data, mbr_data); end
        checks++; if (err_timeout !== 1'b0 || err_rdwr !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b %0b want 0", err_timeout, err_rdwr); end
        idle_inputs(); reset = 1;
        cyc();
        $display("reset: outputs cleared");
    endtask

    task automatic test_read_1cycle();
        mar = 32'h10; mir_rd = 1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rd_issue_stall: got %0b want 0", stall); end
        cyc();
        mir_rd = 0; mar = 32'hFFFF_FFF0;
        checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin errors++; $display("FAIL rd_req: got req=%0b we=%0b want 1 0", dmem_req, dmem_we); end
        checks++; if (dmem_addr !== 30'h4) begin errors++; $display("FAIL rd_addr: got %h want 4", dmem_addr); end
        dmem_ack = 1; dmem_rdata = 32'hCAFE_BABE; #1;
        cyc();
        dmem_ack = 0; dmem_rdata = '0;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rd_req_drop: got %0b want 0", dmem_req); end
        checks++; if (mdr_load !== 1'b1 || mdr_data !== 32'hCAFE_BABE) begin errors++; $display("FAIL rd_load: got %0b %h want 1 cafebabe", mdr_load, mdr_data); end
        use_mdr = 1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rd_use_stall: got %0b want 0", stall); end
        cyc();
        use_mdr = 0;
        checks++; if (mdr_load !== 1'b0) begin errors++; $display("FAIL rd_load_pulse: got %0b want 0", mdr_load); end
        $display("read: addr=0x10 data=%h", mdr_data);
    endtask

    task automatic test_write_latency();
        mar = 32'h40; mdr = 32'h1234_5678; mir_wr = 1; #1;
        cyc();
        mir_wr = 0; mdr = 32'hDEAD_BEEF; mar = 32'h0;
        for (int k = 0; k < 5; k++) begin
            checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin errors++; $display("FAIL wr_req_%0d: got req=%0b we=%0b want 1 1", k, dmem_req, dmem_we); end
            checks++; if (dmem_wdata !== 32'h1234_5678 || dmem_addr !== 30'h10) begin errors++; $display("FAIL wr_hold_%0d: got w=%h a=%h want 12345678 10", k, dmem_wdata, dmem_addr); end
            mir_wr = (k >= 1); dmem_ack = (k == 4); #1;
            checks++; if (stall !== (k >= 1)) begin errors++; $display("FAIL wr_busy_stall_%0d: got %0b want %0b", k, stall, (k >= 1)); end
            cyc();
        end
        dmem_ack = 0;
        checks++; if (dmem_req !== 1'b0 || mdr_load !== 1'b0) begin errors++; $display("FAIL wr_done: got req=%0b load=%0b want 0 0", dmem_req, mdr_load); end
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wr_release: got %0b want 0", stall); end
        cyc();
        mir_wr = 0;
        checks++; if (dmem_req !== 1'b1 || dmem_wdata !== 32'hDEAD_BEEF || dmem_addr !== 30'h0) begin errors++; $display("FAIL wr_second: got req=%0b w=%h a=%h want 1 deadbeef 0", dmem_req, dmem_wdata, dmem_addr); end
        dmem_ack = 1;
        cyc();
        dmem_ack = 0;
        checks++; if (dmem_req !== 1'b0 || mdr_load !== 1'b0) begin errors++; $display("FAIL wr_second_done: got req=%0b load=%0b want 0 0", dmem_req, mdr_load); end
        $display("write: 0x12345678 held 5 cycles, then 0xdeadbeef");
    endtask

    task automatic test_concurrent();
        pc = 32'h7; mar = 32'h20; mir_fetch = 1; mir_rd = 1; #1;
        cyc();
        mir_fetch = 0; mir_rd = 0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h7) begin errors++; $display("FAIL cc_freq: got %0b %h want 1 7", imem_req, imem_addr); end
        checks++; if (dmem_req !== 1'b1 || dmem_addr !== 30'h8) begin errors++; $display("FAIL cc_dreq: got %0b %h want 1 8", dmem_req, dmem_addr); end
        use_mbr = 1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL cc_mbr_stall: got %0b want 1", stall); end
        cyc();
        use_mbr = 0;
        dmem_ack = 1; dmem_rdata = 32'h1122_3344; imem_ack = 1; imem_rdata = 8'hA5; #1;
        cyc();
        idle_inputs();
        checks++; if (mbr_load !== 1'b1 || mbr_data !== 8'hA5) begin errors++; $display("FAIL cc_mbr: got %0b %h want 1 a5", mbr_load, mbr_data); end
        checks++; if (mdr_load !== 1'b1 || mdr_data !== 32'h1122_3344) begin errors++; $display("FAIL cc_mdr: got %0b %h want 1 11223344", mdr_load, mdr_data); end
        checks++; if (dmem_req !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL cc_drop: got %0b %0b want 0 0", dmem_req, imem_req); end
        use_mdr = 1; use_mbr = 1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL cc_release: got %0b want 0", stall); end
        cyc();
        idle_inputs();
        $display("concurrent: mbr=%h mdr=%h", mbr_data, mdr_data);
    endtask

    task automatic test_rdwr();
        checks++; if (err_rdwr !== 1'b0) begin errors++; $display("FAIL rdwr_pre: got %0b want 0", err_rdwr); end
        mar = 32'h100; mdr = 32'h55AA_55AA; mir_rd = 1; mir_wr = 1; #1;
        cyc();
        mir_rd = 0; mir_wr = 0;
        checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 32'h55AA_55AA) begin errors++; $display("FAIL rdwr_write: got req=%0b we=%0b w=%h want 1 1 55aa55aa", dmem_req, dmem_we, dmem_wdata); end
        checks++; if (err_rdwr !== 1'b1) begin errors++; $display("FAIL rdwr_flag: got %0b want 1", err_rdwr); end
        dmem_ack = 1;
        cyc();
        dmem_ack = 0;
        checks++; if (mdr_load !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL rdwr_noload: got load=%0b req=%0b want 0 0", mdr_load, dmem_req); end
        $display("rd+wr: write issued, err_rdwr=%0b", err_rdwr);
    endtask

    task automatic test_timeout();
        int n;
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_pre: got %0b want 0", err_timeout); end
        mar = 32'h80; mir_rd = 1; #1;
        cyc();
        mir_rd = 0; use_mdr = 1;
        n = 0;
        while (dmem_req === 1'b1 && n < 40) begin
            n++;
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL to_stall_%0d: got %0b want 1", n, stall); end
            cyc();
        end
        checks++; if (n != TIMEOUT) begin errors++; $display("FAIL to_len: got %0d want %0d", n, TIMEOUT); end
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %0b want 1", err_timeout); end
        checks++; if (mdr_load !== 1'b1 || mdr_data !== '0) begin errors++; $display("FAIL to_load: got %0b %h want 1 0", mdr_load, mdr_data); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL to_release: got %0b want 0", stall); end
        cyc();
        use_mdr = 0;
        $display("timeout: req high %0d cycles", n);
    endtask

    // Randomized read/write/fetch transactions served from a small word memory.
    task automatic test_random();
        logic [DATA_W-1:0] mem [0:7];
        for (int i = 0; i < 8; i++) mem[i] = $urandom;
        for (int t = 0; t < 40; t++) begin
            int op, d_left, f_left, n, widx;
            logic do_fetch, d_due, f_due;
            logic [DATA_W-1:0] iss_mar, iss_mdr, iss_pc, d_exp;
            logic [BYTE_W-1:0] f_exp;
            op = $urandom_range(0, 2);
            do_fetch = (op == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            widx = $urandom_range(0, 7);
            iss_mar = DATA_W'(widx * 4 + $urandom_range(0, 3));
            iss_mdr = $urandom;
            iss_pc = $urandom;
            d_left = (op < 2) ? $urandom_range(1, 6) : 0;
            f_left = do_fetch ? $urandom_range(1, 6) : 0;
            d_due = 0; f_due = 0; d_exp = '0; f_exp = '0;
            mar = iss_mar; mdr = iss_mdr; pc = iss_pc;
            mir_rd = (op == 0); mir_wr = (op == 1); mir_fetch = do_fetch;
            dmem_ack = 0; imem_ack = 0; #1;
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rnd_issue_stall_%0d: got %0b want 0", t, stall); end
            cyc();
            mir_rd = 0; mir_wr = 0; mir_fetch = 0;
            n = 0;
            while ((d_left > 0 || f_left > 0 || d_due || f_due) && n < 20) begin
                mar = $urandom; mdr = $urandom; pc = $urandom;
                checks++; if (mdr_load !== (d_due && op == 0)) begin errors++; $display("FAIL rnd_mdr_load_%0d: got %0b want %0b", t, mdr_load, (d_due && op == 0)); end
                if (d_due && op == 0) begin
                    checks++; if (mdr_data !== d_exp) begin errors++; $display("FAIL rnd_mdr_data_%0d: got %h want %h", t, mdr_data, d_exp); end
                end
                checks++; if (mbr_load !== f_due) begin errors++; $display("FAIL rnd_mbr_load_%0d: got %0b want %0b", t, mbr_load, f_due); end
                if (f_due) begin
                    checks++; if (mbr_data !== f_exp) begin errors++; $display("FAIL rnd_mbr_data_%0d: got %h want %h", t, mbr_data, f_exp); end
                end
                d_due = 0; f_due = 0;
                if (d_left > 0) begin
                    checks++; if (dmem_req !== 1'b1 || dmem_we !== (op == 1) || dmem_addr !== 30'(iss_mar / 4)) begin errors++; $display("FAIL rnd_dreq_%0d: got req=%0b we=%0b a=%h want 1 %0b %h", t, dmem_req, dmem_we, dmem_addr, (op == 1), 30'(iss_mar / 4)); end
                    if (op == 1) begin
                        checks++; if (dmem_wdata !== iss_mdr) begin errors++; $display("FAIL rnd_wdata_%0d: got %h want %h", t, dmem_wdata, iss_mdr); end
                    end
                    d_left--;
                    dmem_rdata = $urandom;
                    dmem_ack = (d_left == 0);
                    if (d_left == 0) begin
                        if (op == 0) begin dmem_rdata = mem[widx]; d_exp = mem[widx]; end
                        else mem[widx] = iss_mdr;
                        d_due = 1;
                    end
                end else begin
                    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rnd_didle_%0d: got %0b want 0", t, dmem_req); end
                    dmem_ack = 1'($urandom_range(0, 1));
                    dmem_rdata = $urandom;
                end
                if (f_left > 0) begin
                    checks++; if (imem_req !== 1'b1 || imem_addr !== iss_pc) begin errors++; $display("FAIL rnd_freq_%0d: got req=%0b a=%h want 1 %h", t, imem_req, imem_addr, iss_pc); end
                    f_left--;
                    imem_rdata = 8'($urandom);
                    imem_ack = (f_left == 0);
                    if (f_left == 0) begin f_exp = imem_rdata; f_due = 1; end
                end else begin
                    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rnd_fidle_%0d: got %0b want 0", t, imem_req); end
                    imem_ack = 1'($urandom_range(0, 1));
                    imem_rdata = 8'($urandom);
                end
                n++;
                cyc();
            end
            dmem_ack = 0; imem_ack = 0;
            checks++; if (n >= 20) begin errors++; $display("FAIL rnd_bound_%0d: got %0d cycles want < 20", t, n); end
            $display("txn %0d: op=%0d fetch=%0b waddr=%0d pc=%h cycles=%0d", t, op, do_fetch, widx, iss_pc, n);
        end
    endtask

    task automatic test_reset_mid();
        mar = 32'h44; pc = 32'h99; mir_rd = 1; mir_fetch = 1; #1;
        cyc();
        mir_rd = 0; mir_fetch = 0;
        checks++; if (dmem_req !== 1'b1 || imem_req !== 1'b1) begin errors++; $display("FAIL rm_req: got %0b %0b want 1 1", dmem_req, imem_req); end
        reset = 0;
        cyc();
        checks++; if (dmem_req !== 1'b0 || imem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rm_clear: got d=%0b f=%0b s=%0b want 0", dmem_req, imem_req, stall); end
        checks++; if (err_timeout !== 1'b0 || err_rdwr !== 1'b0 || dmem_addr !== '0 || imem_addr !== '0) begin errors++; $display("FAIL rm_regs: got et=%0b er=%0b a=%h ia=%h want 0", err_timeout, err_rdwr, dmem_addr, imem_addr); end
        reset = 1;
        dmem_ack = 1; dmem_rdata = 32'hFACE_FEED; imem_ack = 1; imem_rdata = 8'h3C;
        cyc();
        cyc();
        checks++; if (mdr_load !== 1'b0 || mbr_load !== 1'b0 || mdr_data !== '0) begin errors++; $display("FAIL rm_late_ack: got %0b %0b %h want 0 0 0", mdr_load, mbr_load, mdr_data); end
        idle_inputs();
        $display("reset mid-transfer: late acks ignored");
    endtask

    initial begin
        idle_inputs();
        reset = 0; mar = '0; mdr = '0; pc = '0;
        test_reset();
        test_read_1cycle();
        test_write_latency();
        test_concurrent();
        test_rdwr();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mic1_mem_ctrl.md
Name: mic1_mem_ctrl

Overview:
- Parametrised memory-interface controller for the MIC-1 core: services the rd, wr and fetch microinstruction bits against variable-latency data and program memories.
- Sits between datapath registers (MAR/MDR/PC/MBR), control path and the two memory ports.
- Generalises the fixed one-cycle memory timing to arbitrary-latency req/ack ports, with a stall to the microsequencer and a per-channel timeout.

Parameters:
- DATA_W, 32, data word width (MAR/MDR/PC width)
- BYTE_W, 8, fetch width (MBR)
- TIMEOUT, 15, max cycles waiting for ack before abort (>=1)
- TO_W, 4, timeout counter width; must hold TIMEOUT

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- mir_rd  in  1  microinstruction read bit
- mir_wr  in  1  microinstruction write bit
- mir_fetch  in  1  microinstruction fetch bit
- use_mdr  in  1  current microinstruction reads MDR on B bus
- use_mbr  in  1  current microinstruction reads MBR/MBRU on B bus
- mar  in  DATA_W  MAR value
- mdr  in  DATA_W  MDR value
- pc  in  DATA_W  PC value
- stall  out  1  hold MPC/MIR; suppress register writes this cycle
- mdr_load  out  1  one-cycle pulse: write mdr_data into MDR
- mdr_data  out  DATA_W  read data for MDR
- mbr_load  out  1  one-cycle pulse: write mbr_data into MBR
- mbr_data  out  BYTE_W  fetched byte
- dmem_req  out  1  data request, held until ack
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  DATA_W-2  word address = mar[DATA_W-1:2]
- dmem_wdata  out  DATA_W  write data
- dmem_ack  in  1  data transfer complete
- dmem_rdata  in  DATA_W  read data, valid with ack
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  DATA_W  byte address = pc
- imem_ack  in  1  fetch complete
- imem_rdata  in  BYTE_W  fetched byte, valid with ack
- err_timeout  out  1  sticky: a channel timed out
- err_rdwr  out  1  sticky: rd and wr asserted together

Behaviour:
- Reset (reset==0 at a clock edge): all outputs 0, both FSMs to IDLE, timeout counters 0, sticky errors cleared. Reset mid-transfer aborts: req drops next cycle; a late ack is ignored.
- Two independent channels, data (D) and fetch (F), each with FSM IDLE -> BUSY -> IDLE.
- Issue: in a non-stalled cycle, mir_rd|mir_wr with D IDLE latches address/we/wdata (mdr snapshot) and D goes BUSY; dmem_req rises the next cycle. Same for mir_fetch on F with pc.
- rd & wr together: treated as write; err_rdwr set.
- Registered request: address/wdata stable while req is high; later changes to mar/mdr/pc have no effect.
- BUSY: req held. Ack sampled only while req=1; on ack, req drops next cycle, FSM returns to IDLE.
- Read data: on D read ack, mdr_load=1 and mdr_data=dmem_rdata the following cycle (a registered pulse). Writes produce no mdr_load.
- Fetch data: on F ack, mbr_load/mbr_data behave the same way from imem_rdata.
- Load priority: mdr_load/mbr_load override a C-bus write to the same register in that cycle (datapath rule).
- stall (combinational) = (use_mdr & D has a pending read whose load has not yet pulsed) | (use_mbr & F has a pending fetch whose load has not yet pulsed) | ((mir_rd|mir_wr) & D BUSY) | (mir_fetch & F BUSY).
  - Consequence: with a 1-cycle ack, the MIC-1 rule of "data usable two microinstructions later" holds with no stall.
  - A stalled cycle issues nothing; the request is re-evaluated the next cycle.
- Timeout: counter counts BUSY cycles with req high. When it reaches TIMEOUT without ack, the request is aborted: FSM to IDLE, err_timeout set.
  - Aborted read: load pulse with data 0, so dependent stalls release.
- D and F may both be busy concurrently; acks on both channels in the same cycle are both honoured.

Decomposition:
- Shared package mic1_pkg: channel state enum (IDLE, BUSY), default widths, and the MIR bit-position constants for rd/wr/fetch.
- One natural sub-module: mic1_mem_chan (FSM + request registers + timeout counter), instantiated twice (D with write path, F read-only via a parameter).
- The top handles the stall logic and error flags.

Test Plan:
- Read, 1-cycle ack: mar=0x10, mir_rd pulse; dmem_req the next cycle with dmem_addr=0x4; ack+rdata=0xCAFEBABE the cycle after -> mdr_load with 0xCAFEBABE the next cycle; use_mdr two microinstructions later -> stall never asserts.
- Write, 5-cycle latency: mdr=0x12345678, mir_wr, then mdr changed -> dmem_wdata stays 0x12345678 and dmem_we=1 until ack; a second mir_wr during BUSY -> stall=1 until IDLE.
- Concurrent fetch + read: pc=0x7, mir_fetch and mir_rd in the same cycle; acks in the same cycle -> mbr_load and mdr_load pulse together with correct data; use_mbr before ack -> stall.
- Timeout: TIMEOUT=15, never ack -> req high exactly 15 cycles, then drops; err_timeout=1; mdr_load with data 0.
- rd & wr together -> a write issued, err_rdwr=1.
- Reset mid-transfer: reset low while req is high -> next cycle all outputs 0; an ack arriving later produces no load.
